// File: rtl/onehot_strobe_decoder.sv
// Buffers 3-bit codes in a small FIFO and replays each one as an 8-bit one-hot
// word held for HOLD cycles, back-to-back while codes remain queued.
module onehot_strobe_decoder #(
    parameter int HOLD  = 4,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    code,
    output logic [7:0]    N,
    output logic          out_valid,
    output logic          last,
    output logic [CW-1:0] level
);

    localparam int            AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0]    HOLD_RELOAD = 8'(HOLD - 1);
    localparam logic [CW-1:0] FULL_LEVEL  = CW'(DEPTH);

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } state_t;

    state_t        r_state;
    logic [2:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [7:0]    r_cnt;

    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic [7:0]    w_headOneHot;

    assign in_ready     = (level != FULL_LEVEL);
    assign w_push       = in_valid && in_ready;
    assign w_empty      = (level == '0);
    // A pop happens whenever a new word is due: from idle, or on the final hold cycle.
    assign w_pop        = !w_empty && ((r_state == ST_IDLE) || (r_cnt == 8'd0));
    assign w_headOneHot = 8'd1 << r_mem[r_rdPtr];
    assign last         = out_valid && (r_cnt == 8'd0);

    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_mem[r_wrPtr] <= code;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            level   <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            if (w_push && !w_pop) begin
                level <= level + CW'(1);
            end else if (!w_push && w_pop) begin
                level <= level - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            N         <= 8'd0;
            out_valid <= 1'b0;
            r_cnt     <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        N         <= w_headOneHot;
                        out_valid <= 1'b1;
                        r_cnt     <= HOLD_RELOAD;
                        r_state   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt != 8'd0) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else if (w_pop) begin
                        N     <= w_headOneHot;
                        r_cnt <= HOLD_RELOAD;
                    end else begin
                        N         <= 8'd0;
                        out_valid <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onehot_strobe_decoder.sv
// Directed bench for onehot_strobe_decoder: a HOLD=4 instance checked by a code
// scoreboard plus cycle-exact steps, and a HOLD=1 instance for single-cycle words.
module tb_onehot_strobe_decoder;

    localparam int HOLD4 = 4;

    logic       clk = 1'b0;
    logic       reset;

    logic       in_valid;
    logic       in_ready;
    logic [2:0] code;
    logic [7:0] N;
    logic       out_valid;
    logic       last;
    logic [2:0] level;

    logic       in_valid1;
    logic       in_ready1;
    logic [2:0] code1;
    logic [7:0] N1;
    logic       out_valid1;
    logic       last1;
    logic [2:0] level1;

    int         vectors = 0;
    int         errors  = 0;

    logic [2:0] sbq[$];
    int         holdCnt   = 0;
    logic       prevValid = 1'b0;
    logic [7:0] prevN     = 8'd0;
    int         wordsSeen = 0;
    logic       monPush;
    logic [2:0] monCode;
    logic       monReset;
    logic [2:0] monExp;

    onehot_strobe_decoder #(.HOLD(HOLD4), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .code      (code),
        .N         (N),
        .out_valid (out_valid),
        .last      (last),
        .level     (level)
    );

    onehot_strobe_decoder #(.HOLD(1), .DEPTH(4)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .code      (code1),
        .N         (N1),
        .out_valid (out_valid1),
        .last      (last1),
        .level     (level1)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] c);
        in_valid = v;
        code     = c;
        @(negedge clk);
    endtask

    task automatic waitIdle(input string tag);
        for (int i = 0; i < 100 && (out_valid || level != 3'd0); i++) begin
            @(negedge clk);
        end
        checkOutput(tag, {out_valid, level}, 0);
    endtask

    // Scoreboard: accepted codes queue up at the edge they are taken and are
    // retired when the matching word starts; every word must last HOLD4 cycles.
    always @(posedge clk) begin
        monReset = reset;
        monPush  = in_valid && in_ready && !reset;
        monCode  = code;
        #1;
        if (monReset) begin
            sbq.delete();
            holdCnt   = 0;
            prevValid = 1'b0;
            checkOutput("rstN", N, 0);
            checkOutput("rstValid", out_valid, 0);
            checkOutput("rstLevel", level, 0);
        end else begin
            if (monPush) begin
                sbq.push_back(monCode);
            end
            if (out_valid) begin
                checkOutput("onehot", $countones(N), 1);
                if (!prevValid || holdCnt == HOLD4) begin
                    checkOutput("sbNonEmpty", sbq.size() != 0, 1);
                    if (sbq.size() != 0) begin
                        monExp = sbq.pop_front();
                        checkOutput("sbOrder", N, 8'd1 << monExp);
                    end
                    holdCnt = 1;
                    wordsSeen++;
                end else begin
                    checkOutput("holdStable", N, prevN);
                    holdCnt++;
                end
                checkOutput("lastFlag", last, holdCnt == HOLD4);
            end else begin
                checkOutput("idleN", N, 0);
                checkOutput("idleLast", last, 0);
                if (prevValid && holdCnt != HOLD4) begin
                    checkOutput("wordLen", holdCnt, HOLD4);
                end
            end
            prevValid = out_valid;
            prevN     = N;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0] seq2 [3];
        logic [2:0] seq3 [10];
        logic [2:0] seq4 [3];
        logic [2:0] seq5 [4];
        logic [7:0] expN;
        logic [2:0] peak;
        logic       sawFull;
        logic       wasReady;
        int         idx;
        int         base;

        seq2 = '{3'd0, 3'd7, 3'd5};
        seq3 = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
        seq4 = '{3'd2, 3'd2, 3'd6};
        seq5 = '{3'd4, 3'd1, 3'd2, 3'd3};

        reset     = 1'b1;
        in_valid  = 1'b0;
        code      = 3'd0;
        in_valid1 = 1'b0;
        code1     = 3'd0;
        @(negedge clk);
        checkOutput("resetReady", in_ready, 1);
        checkOutput("resetLast", last, 0);
        checkOutput("resetN1", N1, 0);
        reset = 1'b0;
        @(negedge clk);

        // Single code 3: one cycle in the FIFO, then four cycles of 8'h08.
        applyStimulus(1'b1, 3'd3);
        checkOutput("t1NoBypass", N, 0);
        checkOutput("t1Level", level, 1);
        applyStimulus(1'b0, 3'd0);
        for (int j = 0; j < 4; j++) begin
            checkOutput("t1Word", N, 8'h08);
            checkOutput("t1Last", last, j == 3);
            @(negedge clk);
        end
        checkOutput("t1IdleN", N, 0);
        checkOutput("t1IdleValid", out_valid, 0);
        checkOutput("t1IdleLevel", level, 0);

        // Codes 0,7,5 back to back: twelve contiguous word cycles.
        peak = 3'd0;
        for (int t = 0; t < 14; t++) begin
            if (t < 3) applyStimulus(1'b1, seq2[t]);
            else       applyStimulus(1'b0, 3'd0);
            if (t == 0 || t == 13) expN = 8'd0;
            else                   expN = 8'd1 << seq2[(t - 1) / 4];
            checkOutput("t2Word", N, expN);
            if (level > peak) peak = level;
        end
        checkOutput("t2Peak", peak, 2);
        checkOutput("t2Idle", out_valid, 0);

        // Ten codes against a four-deep FIFO with the producer holding each one.
        base    = wordsSeen;
        idx     = 0;
        sawFull = 1'b0;
        for (int cyc = 0; cyc < 200 && idx < 10; cyc++) begin
            in_valid = 1'b1;
            code     = seq3[idx];
            checkOutput("t3ReadyVsLevel", in_ready, level != 3'd4);
            if (!in_ready) sawFull = 1'b1;
            wasReady = in_ready;
            @(negedge clk);
            if (wasReady) idx++;
        end
        in_valid = 1'b0;
        checkOutput("t3AllAccepted", idx, 10);
        checkOutput("t3SawFull", sawFull, 1);
        waitIdle("t3Drain");
        checkOutput("t3Words", wordsSeen - base, 10);
        checkOutput("t3SbEmpty", sbq.size(), 0);

        // HOLD=1 instance: one cycle per word, last on every word cycle.
        for (int t = 0; t < 5; t++) begin
            in_valid1 = (t < 3);
            code1     = (t < 3) ? seq4[t] : 3'd0;
            @(negedge clk);
            if (t >= 1 && t <= 3) expN = 8'd1 << seq4[t - 1];
            else                  expN = 8'd0;
            checkOutput("t4Word", N1, expN);
            checkOutput("t4Last", last1, t >= 1 && t <= 3);
        end
        in_valid1 = 1'b0;

        // Reset in the middle of word 8'h10 with three codes still queued.
        for (int t = 0; t < 4; t++) begin
            applyStimulus(1'b1, seq5[t]);
        end
        in_valid = 1'b0;
        checkOutput("t5MidN", N, 8'h10);
        checkOutput("t5MidLevel", level, 3);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("t5RstN", N, 0);
        checkOutput("t5RstValid", out_valid, 0);
        checkOutput("t5RstLevel", level, 0);
        checkOutput("t5RstReady", in_ready, 1);
        reset = 1'b0;
        applyStimulus(1'b1, 3'd1);
        checkOutput("t5Queued", N, 0);
        checkOutput("t5QueuedLevel", level, 1);
        applyStimulus(1'b0, 3'd0);
        checkOutput("t5Word", N, 8'h02);
        checkOutput("t5Valid", out_valid, 1);
        waitIdle("t5Drain");

        // Push on the final cycle of the only word: exactly one zero cycle between.
        for (int t = 0; t < 11; t++) begin
            if (t == 0)      applyStimulus(1'b1, 3'd6);
            else if (t == 5) applyStimulus(1'b1, 3'd2);
            else             applyStimulus(1'b0, 3'd0);
            if (t >= 1 && t <= 4)      expN = 8'h40;
            else if (t >= 6 && t <= 9) expN = 8'h04;
            else                       expN = 8'h00;
            checkOutput("t6Word", N, expN);
            checkOutput("t6Last", last, t == 4 || t == 9);
            if (t == 5) checkOutput("t6GapLevel", level, 1);
        end
        waitIdle("t6Drain");
        checkOutput("finalSbEmpty", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/onehot_strobe_decoder.md
Name: onehot_strobe_decoder

Overview:
- Inverse of the team's 8-to-3 one-hot encoder. It accepts 3-bit codes through a valid/ready handshake and buffers them in a small FIFO.
- It replays each code as an 8-bit one-hot word on N, held for HOLD cycles per code.
- It sits between a code producer (controller or encoder output) and one-hot consumers such as LED banks, chip-selects and strobes.

Parameters:
- HOLD, 4: cycles each one-hot word is driven; legal range 1..255.
- DEPTH, 4: FIFO entries; power of 2, at least 2.
- CW, $clog2(DEPTH+1): width of the occupancy port; derived, never overridden.

Ports:
- clk  input  1  single clock, all state on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising clk.
- in_valid  input  1  producer presents code this cycle.
- in_ready  output  1  block can accept a code this cycle.
- code  input  3  index to decode (0 -> N[0], ... 7 -> N[7]).
- N  output  8  registered one-hot word; all zero when idle.
- out_valid  output  1  high while N carries a word.
- last  output  1  high on the final hold cycle of the current word.
- level  output  CW  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset, asserted on any edge, forces: N=0, out_valid=0, last=0, level=0, FIFO pointers=0, hold counter=0, state=IDLE.
  - in_ready is combinational (level != DEPTH), so it reads 1 during reset.
  - Any word in progress and all buffered codes are discarded; no partial word resumes.
- Push:
  - in_ready = (level != DEPTH). It depends on occupancy only, never on a same-cycle pop.
  - A code is written when in_valid && in_ready.
  - in_valid while full is ignored. The producer must hold the code; nothing is lost or overwritten.
- FIFO:
  - Circular buffer with read and write pointers of log2(DEPTH) bits; both wrap DEPTH-1 -> 0.
  - level: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop.
- State machine, two states:
  - IDLE: N=0, out_valid=0. If level>0, pop the head, set N <= 8'b1 << code, out_valid <= 1, cnt <= HOLD-1, and go to HOLD.
  - HOLD: N stable. If cnt>0, cnt <= cnt-1.
  - HOLD with cnt==0 (final cycle) and level>0: pop the next code and reload N, cnt <= HOLD-1, staying in HOLD. Words play back-to-back with no zero gap.
  - HOLD with cnt==0 and level==0: N <= 0, out_valid <= 0, go to IDLE.
- last = out_valid && (cnt==0). With HOLD=1, last is high on every word cycle.
- Latency: a code pushed into an empty FIFO in IDLE at edge k appears on N at edge k+1. This is the minimum latency; there is no combinational bypass.
- Push into an empty FIFO on the same edge as the HOLD->IDLE transition: the code is stored, N goes to 0 for exactly one cycle, then the word plays. This one-cycle gap is required behaviour.
- Invariants:
  - N has popcount 0 when out_valid=0 and exactly 1 when out_valid=1.
  - Codes exit in the order they were accepted.
  - Each word is held exactly HOLD cycles.
- Arithmetic: the one-hot word is 8'b1 << code, with code fully 3 bits. cnt is 8 bits and never wraps below 0.

Test Plan:
- Reset, then code=3 with a 1-cycle in_valid (HOLD=4) -> N=8'h08 for 4 cycles starting one cycle after acceptance; last on the 4th cycle; then N=0, out_valid=0, level back to 0.
- Push codes 0,7,5 in consecutive cycles -> N=01,80,20, each for 4 cycles, no zero cycles between words; level peaks at 2.
- Hold in_valid for 10 cycles with DEPTH=4, codes 1..7,0,1,2 -> in_ready drops when level=4 and reasserts as pops occur; all 10 words emerge in order with none dropped.
- HOLD=1, stream codes 2,2,6 -> N=04,04,40 on consecutive cycles; last high on all three.
- Assert reset mid-word (N=8'h10, level=3) -> next cycle N=0, out_valid=0, level=0; the next accepted code 1 yields N=02 with 1-cycle latency.
- Push arrives on the final cycle of the last buffered word -> exactly one N=0 cycle, then the new word plays for HOLD cycles.
